// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package ex_muldiv_pkg;

  localparam int MD_CNT_WIDTH = 6;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  function automatic logic [31:0] md_abs(
    input logic [31:0] x,
    input logic        neg
  );
    return neg ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M unit: shift-add multiply, restoring divide,
// one step per cycle, stalls the pipeline while busy.
import ex_muldiv_pkg::*;

module ex_muldiv #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      md_op_i,
  input  logic [XLEN-1:0] rs1_rdata_i,
  input  logic [XLEN-1:0] rs2_rdata_i,
  input  logic [4:0]      rd_waddr_i,
  input  logic            flush_i,
  output logic            hold_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_waddr_o
);

  localparam logic [MD_CNT_WIDTH-1:0] CNT_LAST =
    MD_CNT_WIDTH'(ITER - 1);

  md_state_e               r_state;
  md_op_e                  r_op;
  logic [MD_CNT_WIDTH-1:0] r_cnt;
  logic [63:0]             r_acc;
  logic [31:0]             r_m;
  logic                    r_neg;
  logic                    r_neg_rem;
  logic                    r_done;
  logic [31:0]             r_result;
  logic [4:0]              r_rd;

  md_op_e      w_op;
  logic        w_s1;
  logic        w_s2;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_is_div;
  logic        w_div0;
  logic        w_ovf;
  logic        w_special;
  logic [31:0] w_spec_res;

  assign w_op     = md_op_e'(md_op_i);
  assign w_is_div = md_op_i[2];
  assign w_s1     = (w_op != MD_MULHU) && (w_op != MD_DIVU) &&
                    (w_op != MD_REMU);
  assign w_s2     = w_s1 && (w_op != MD_MULHSU);
  assign w_a_neg  = w_s1 & rs1_rdata_i[31];
  assign w_b_neg  = w_s2 & rs2_rdata_i[31];
  assign w_a_mag  = md_abs(rs1_rdata_i, w_a_neg);
  assign w_b_mag  = md_abs(rs2_rdata_i, w_b_neg);

  assign w_div0 = w_is_div && (rs2_rdata_i == 32'd0);
  assign w_ovf  = ((w_op == MD_DIV) || (w_op == MD_REM)) &&
                  (rs1_rdata_i == 32'h8000_0000) &&
                  (rs2_rdata_i == 32'hFFFF_FFFF);
  assign w_special = w_div0 | w_ovf;

  always_comb begin
    w_spec_res = 32'd0;
    if (w_div0)
      w_spec_res = md_op_i[1] ? rs1_rdata_i : 32'hFFFF_FFFF;
    else if (w_op == MD_DIV)
      w_spec_res = 32'h8000_0000;
  end

  // Datapath steps; the multiplier sits in the accumulator low half.
  logic [32:0] w_sum;
  logic [32:0] w_rem;
  logic [31:0] w_sub;
  logic        w_ge;
  logic [63:0] w_acc_nxt;

  assign w_sum = {1'b0, r_acc[63:32]} +
                 {1'b0, (r_acc[0] ? r_m : 32'd0)};
  assign w_rem = r_acc[63:31];
  assign w_ge  = w_rem >= {1'b0, r_m};
  assign w_sub = w_rem[31:0] - r_m;

  always_comb begin
    if (r_op[2])
      w_acc_nxt = {(w_ge ? w_sub : w_rem[31:0]),
                   r_acc[30:0], w_ge};
    else
      w_acc_nxt = {w_sum, r_acc[31:1]};
  end

  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rmd;
  logic [31:0] w_fix;

  assign w_prod = r_neg ? (~w_acc_nxt + 64'd1) : w_acc_nxt;
  assign w_quo  = md_abs(w_acc_nxt[31:0], r_neg);
  assign w_rmd  = md_abs(w_acc_nxt[63:32], r_neg_rem);

  always_comb begin
    w_fix = 32'd0;
    unique case (r_op)
      MD_MUL:                      w_fix = w_prod[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_fix = w_prod[63:32];
      MD_DIV, MD_DIVU:             w_fix = w_quo;
      MD_REM, MD_REMU:             w_fix = w_rmd;
      default:                     w_fix = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= MD_IDLE;
      r_op      <= MD_MUL;
      r_cnt     <= '0;
      r_acc     <= 64'd0;
      r_m       <= 32'd0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= 32'd0;
      r_rd      <= 5'd0;
    end else if (flush_i) begin
      r_state <= MD_IDLE;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        MD_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_op <= w_op;
            r_rd <= rd_waddr_i;
            if (w_special) begin
              r_result <= w_spec_res;
              r_done   <= 1'b1;
              r_state  <= MD_DONE;
            end else begin
              r_m       <= w_is_div ? w_b_mag : w_a_mag;
              r_acc     <= {32'd0, (w_is_div ? w_a_mag : w_b_mag)};
              r_neg     <= w_a_neg ^ w_b_neg;
              r_neg_rem <= w_a_neg;
              r_cnt     <= '0;
              r_state   <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_result <= w_fix;
            r_done   <= 1'b1;
            r_state  <= MD_DONE;
          end
        end
        MD_DONE: begin
          r_done  <= 1'b0;
          r_state <= MD_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= MD_IDLE;
        end
      endcase
    end
  end

  assign hold_o = ~rst & (((r_state == MD_IDLE) & start_i & ~flush_i) |
                          (r_state == MD_CALC));
  assign done_o     = r_done;
  assign result_o   = r_result;
  assign rd_waddr_o = r_rd;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, hold, results, flush, reset.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  md_op_i;
  logic [31:0] rs1_rdata_i;
  logic [31:0] rs2_rdata_i;
  logic [4:0]  rd_waddr_i;
  logic        flush_i;
  logic        hold_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_waddr_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_res = 32'd0;

  ex_muldiv #(.XLEN(32), .ITER(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .md_op_i    (md_op_i),
    .rs1_rdata_i(rs1_rdata_i),
    .rs2_rdata_i(rs2_rdata_i),
    .rd_waddr_i (rd_waddr_i),
    .flush_i    (flush_i),
    .hold_o     (hold_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_waddr_o (rd_waddr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_op(input string tag,
                       input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] exp,
                       input int lat);
    int cyc;
    int nlow;
    bit seen;
    cyc  = 0;
    nlow = 0;
    seen = 0;
    @(posedge clk); #1;
    start_i     = 1'b1;
    md_op_i     = op;
    rs1_rdata_i = a;
    rs2_rdata_i = b;
    rd_waddr_i  = 5'd5;
    while (!seen && cyc <= 40) begin
      @(negedge clk);
      if (done_o) seen = 1;
      else begin
        if (!hold_o) nlow++;
        cyc++;
      end
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, 32'(cyc), 32'(lat));
    check({tag, "_holdlow"}, 32'(nlow), 32'd0);
    check({tag, "_holddone"}, 32'(hold_o), 32'd0);
    check({tag, "_res"}, result_o, exp);
    check({tag, "_rd"}, 32'(rd_waddr_o), 32'd5);
    @(posedge clk); #1;
    start_i     = 1'b0;
    rd_waddr_i  = 5'd0;
    rs1_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done_o), 32'd0);
    check({tag, "_keep"}, result_o, exp);
    last_res = exp;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int ndone;
    rst = 1'b1;
    start_i = 1'b0;
    md_op_i = 3'd0;
    rs1_rdata_i = 32'd0;
    rs2_rdata_i = 32'd0;
    rd_waddr_i = 5'd0;
    flush_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hold", 32'(hold_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_res", result_o, 32'd0);
    check("rst_rd", 32'(rd_waddr_o), 32'd0);
    rst = 1'b0;

    do_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    do_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    do_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    do_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
    do_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
    do_op("div0",   3'd4, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
    do_op("remu0",  3'd7, 32'd5,        32'd0,        32'd5,        1);
    do_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);
    do_op("remu",   3'd7, 32'd100,      32'd7,        32'd2,        33);
    do_op("divu",   3'd5, 32'hFFFF_FFFE, 32'd2,        32'h7FFF_FFFF, 33);

    // Flush in CALC cycle 10
    @(posedge clk); #1;
    start_i = 1'b1;
    md_op_i = 3'd0;
    rs1_rdata_i = 32'd9;
    rs2_rdata_i = 32'd9;
    rd_waddr_i = 5'd12;
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_hold", 32'(hold_o), 32'd0);
    check("flush_done", 32'(done_o), 32'd0);
    check("flush_res", result_o, last_res);
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_o) ndone++;
    end
    check("flush_nodone", 32'(ndone), 32'd0);
    do_op("divu_pf", 3'd5, 32'd100, 32'd7, 32'd14, 33);

    // Asynchronous reset in CALC cycle 20
    @(posedge clk); #1;
    start_i = 1'b1;
    md_op_i = 3'd0;
    rs1_rdata_i = 32'd11;
    rs2_rdata_i = 32'd13;
    rd_waddr_i = 5'd7;
    repeat (20) @(posedge clk);
    #2;
    start_i = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_hold", 32'(hold_o), 32'd0);
    check("arst_done", 32'(done_o), 32'd0);
    check("arst_res", result_o, 32'd0);
    check("arst_rd", 32'(rd_waddr_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("mul_pr", 3'd0, 32'd3, 32'd4, 32'd12, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
